// File: rtl/charbuf_write_ctrl_pkg.sv
// Shared definitions for the character-buffer write controller: register map,
// status bit positions and fill-engine state type.
package charbuf_write_ctrl_pkg;

  localparam logic [7:0] REG_ADR      = 8'h00;
  localparam logic [7:0] REG_DATA     = 8'h02;
  localparam logic [7:0] REG_DATA_INC = 8'h03;
  localparam logic [7:0] REG_FILL_LEN = 8'h04;
  localparam logic [7:0] REG_FILL_GO  = 8'h05;
  localparam logic [7:0] REG_CLR_ERR  = 8'h06;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_t;

  function automatic logic [15:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic overflow,
                                              input logic [7:0] level);
    logic [15:0] s;
    s = '0;
    s[ST_BUSY]     = busy;
    s[ST_FULL]     = full;
    s[ST_EMPTY]    = empty;
    s[ST_OVERFLOW] = overflow;
    s[ST_LEVEL_LSB +: 8] = level;
    return s;
  endfunction

endpackage

// File: rtl/charbuf_write_ctrl_if.sv
// Host register-write bus as presented by clocked_bus_slave.
interface charbuf_write_ctrl_if;
  logic        do_write;
  logic [7:0]  w_adr;
  logic [15:0] w_data;

  modport master (output do_write, output w_adr, output w_data);
  modport slave  (input  do_write, input  w_adr, input  w_data);
endinterface

// File: rtl/charbuf_write_ctrl_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      level_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop)
      level_nxt = level + 1'b1;
    else if (do_pop && !do_push)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/charbuf_write_ctrl.sv
// Owns the char_buf write port: host cell writes are queued in a small FIFO and
// always win over the hardware fill engine, which uses the port on idle cycles.
module charbuf_write_ctrl
  import charbuf_write_ctrl_pkg::*;
#(
  parameter int ADRW    = 14,
  parameter int DATW    = 8,
  parameter int FIFO_AW = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  charbuf_write_ctrl_if.slave  bus,
  output logic [15:0]          status,
  output logic                 chbuf_we,
  output logic [ADRW-1:0]      chbuf_adr,
  output logic [DATW-1:0]      chbuf_data
);

  localparam logic [ADRW:0] MAX_LEN = {1'b1, {ADRW{1'b0}}};

  fill_state_t          state, state_nxt;
  logic [ADRW-1:0]      hp;
  logic [ADRW:0]        fill_len;
  logic [ADRW:0]        remaining;
  logic [ADRW-1:0]      fill_adr;
  logic [DATW-1:0]      fill_char;
  logic                 overflow;
  logic [ADRW:0]        len_sat;

  logic wr_adr, wr_data, wr_data_inc, wr_len, wr_go, wr_clr;
  logic push, fill_issue, fill_go_ok;

  logic [ADRW+DATW-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic [FIFO_AW:0]     fifo_level;

  assign wr_adr      = bus.do_write && (bus.w_adr == REG_ADR);
  assign wr_data     = bus.do_write && (bus.w_adr == REG_DATA);
  assign wr_data_inc = bus.do_write && (bus.w_adr == REG_DATA_INC);
  assign wr_len      = bus.do_write && (bus.w_adr == REG_FILL_LEN);
  assign wr_go       = bus.do_write && (bus.w_adr == REG_FILL_GO);
  assign wr_clr      = bus.do_write && (bus.w_adr == REG_CLR_ERR);

  assign push       = wr_data || wr_data_inc;
  assign fill_issue = fifo_empty && (state == FILL_RUN);
  assign fill_go_ok = wr_go && (state == FILL_IDLE) && (fill_len != '0);
  assign len_sat    = (bus.w_data > 16'(MAX_LEN)) ? MAX_LEN : bus.w_data[ADRW:0];

  sync_fifo #(.WIDTH(ADRW+DATW), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (!fifo_empty),
    .wdata ({hp, bus.w_data[DATW-1:0]}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= FILL_IDLE;
    else       state <= state_nxt;
  end

  // The fill ends on the cycle its last cell goes out, so a go strobe in that
  // same cycle still sees FILL_RUN and is rejected.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL_IDLE: if (fill_go_ok) state_nxt = FILL_RUN;
      FILL_RUN:  if (fill_issue && (remaining == (ADRW+1)'(1))) state_nxt = FILL_IDLE;
      default:   state_nxt = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hp         <= '0;
      fill_len   <= '0;
      remaining  <= '0;
      fill_adr   <= '0;
      fill_char  <= '0;
      overflow   <= 1'b0;
      chbuf_we   <= 1'b0;
      chbuf_adr  <= '0;
      chbuf_data <= '0;
    end else begin
      if (wr_adr)           hp <= bus.w_data[ADRW-1:0];
      else if (wr_data_inc) hp <= hp + 1'b1;

      if (wr_len) fill_len <= len_sat;

      if (fill_go_ok) begin
        fill_adr  <= hp;
        fill_char <= bus.w_data[DATW-1:0];
        remaining <= fill_len;
      end else if (fill_issue) begin
        fill_adr  <= fill_adr + 1'b1;
        remaining <= remaining - 1'b1;
      end

      if (wr_clr)
        overflow <= 1'b0;
      else if ((push && fifo_full) || (wr_go && (state == FILL_RUN)))
        overflow <= 1'b1;

      if (!fifo_empty) begin
        chbuf_we                <= 1'b1;
        {chbuf_adr, chbuf_data} <= fifo_rdata;
      end else if (fill_issue) begin
        chbuf_we   <= 1'b1;
        chbuf_adr  <= fill_adr;
        chbuf_data <= fill_char;
      end else begin
        chbuf_we   <= 1'b0;
      end
    end
  end

  assign status = pack_status(state == FILL_RUN, fifo_full, fifo_empty, overflow,
                              8'(fifo_level));

endmodule

// File: tb/tb_charbuf_write_ctrl.sv
// Bench for charbuf_write_ctrl: directed scenarios plus random register traffic,
// compared every cycle against a queue-based behavioural model.
module tb_charbuf_write_ctrl;
  import charbuf_write_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        nrst;
  logic [15:0] status;
  logic        chbuf_we;
  logic [13:0] chbuf_adr;
  logic [7:0]  chbuf_data;

  charbuf_write_ctrl_if bus();

  charbuf_write_ctrl #(.ADRW(14), .DATW(8), .FIFO_AW(2)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .bus        (bus),
    .status     (status),
    .chbuf_we   (chbuf_we),
    .chbuf_adr  (chbuf_adr),
    .chbuf_data (chbuf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { logic [13:0] adr; logic [7:0] data; int cyc; } wr_t;
  wr_t log_q[$];

  // Behavioural model state
  logic [21:0] m_q[$];
  logic [13:0] m_hp, m_fadr, m_adr;
  logic [7:0]  m_fchar, m_data;
  int          m_len, m_rem;
  bit          m_busy, m_ovf, m_we;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [15:0] d);
    bus.do_write = 1'b1;
    bus.w_adr    = a;
    bus.w_data   = d;
    @(negedge clk);
    bus.do_write = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkEntry(input string nm, input int i, input logic [13:0] a, input logic [7:0] d);
    checkOutput({nm, "_present"}, 32'(i < log_q.size()), 32'd1);
    if (i < log_q.size()) begin
      checkOutput({nm, "_adr"},  32'(log_q[i].adr),  32'(a));
      checkOutput({nm, "_data"}, 32'(log_q[i].data), 32'(d));
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (nrst && chbuf_we) log_q.push_back('{chbuf_adr, chbuf_data, cyc});

  // Model: one port cycle = drain queue first, else issue one fill cell; then apply the host write.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_q.delete();
      m_hp = '0; m_fadr = '0; m_adr = '0; m_fchar = '0; m_data = '0;
      m_len = 0; m_rem = 0; m_busy = 0; m_ovf = 0; m_we = 0;
    end else begin
      int  sz0;
      bit  busy0;
      logic [21:0] e;
      sz0   = m_q.size();
      busy0 = m_busy;
      if (sz0 > 0) begin
        e = m_q.pop_front();
        m_we = 1; m_adr = e[21:8]; m_data = e[7:0];
      end else if (busy0) begin
        m_we = 1; m_adr = m_fadr; m_data = m_fchar;
        m_fadr = m_fadr + 14'd1;
        m_rem--;
        if (m_rem == 0) m_busy = 0;
      end else begin
        m_we = 0;
      end
      if (bus.do_write) begin
        case (bus.w_adr)
          REG_ADR: m_hp = bus.w_data[13:0];
          REG_DATA, REG_DATA_INC: begin
            if (sz0 == DEPTH) m_ovf = 1;
            else m_q.push_back({m_hp, bus.w_data[7:0]});
            if (bus.w_adr == REG_DATA_INC) m_hp = m_hp + 14'd1;
          end
          REG_FILL_LEN: m_len = (int'(bus.w_data) > 16384) ? 16384 : int'(bus.w_data);
          REG_FILL_GO: begin
            if (busy0) m_ovf = 1;
            else if (m_len != 0) begin
              m_busy = 1; m_fadr = m_hp; m_fchar = bus.w_data[7:0]; m_rem = m_len;
            end
          end
          REG_CLR_ERR: m_ovf = 0;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      logic [15:0] exp_status;
      exp_status = {8'(m_q.size()), 4'b0, m_ovf, m_q.size() == 0, m_q.size() == DEPTH, m_busy};
      checkOutput("cyc_we", 32'(chbuf_we), 32'(m_we));
      checkOutput("cyc_status", 32'(status), 32'(exp_status));
      if (m_we) begin
        checkOutput("cyc_adr",  32'(chbuf_adr),  32'(m_adr));
        checkOutput("cyc_data", 32'(chbuf_data), 32'(m_data));
      end
    end
  end

  initial begin
    int strobe_cyc;
    int nfill;
    bit found_x;
    logic [7:0] radr_tab [7];
    radr_tab = '{REG_ADR, REG_DATA, REG_DATA_INC, REG_FILL_LEN, REG_FILL_GO, REG_CLR_ERR, 8'h00};

    nrst = 1'b0;
    bus.do_write = 1'b0; bus.w_adr = '0; bus.w_data = '0;
    waitCycles(3);
    nrst = 1'b1;
    @(negedge clk);
    checkOutput("reset_status", 32'(status), 32'h0004);
    checkOutput("reset_we", 32'(chbuf_we), 32'd0);
    checkOutput("reset_adr", 32'(chbuf_adr), 32'd0);

    // Host writes with auto-increment
    log_q.delete();
    applyStimulus(REG_ADR, 16'h0123);
    applyStimulus(REG_DATA_INC, 16'h0041);
    strobe_cyc = cyc;
    applyStimulus(REG_DATA_INC, 16'h0042);
    applyStimulus(REG_DATA, 16'h0043);
    waitCycles(4);
    checkEntry("host0", 0, 14'h0123, 8'h41);
    checkEntry("host1", 1, 14'h0124, 8'h42);
    checkEntry("host_hp", 2, 14'h0125, 8'h43);
    if (log_q.size() > 0) checkOutput("host_latency", 32'(log_q[0].cyc - strobe_cyc), 32'd1);
    checkOutput("host_count", 32'(log_q.size()), 32'd3);

    // Fill wrapping across the top of the address space
    log_q.delete();
    applyStimulus(REG_ADR, 16'h3FFE);
    applyStimulus(REG_FILL_LEN, 16'd4);
    applyStimulus(REG_FILL_GO, 16'h0020);
    checkOutput("wrap_busy", 32'(status[ST_BUSY]), 32'd1);
    waitCycles(8);
    checkEntry("wrap0", 0, 14'h3FFE, 8'h20);
    checkEntry("wrap1", 1, 14'h3FFF, 8'h20);
    checkEntry("wrap2", 2, 14'h0000, 8'h20);
    checkEntry("wrap3", 3, 14'h0001, 8'h20);
    checkOutput("wrap_count", 32'(log_q.size()), 32'd4);
    checkOutput("wrap_idle", 32'(status[ST_BUSY]), 32'd0);

    // Host write interleaved into a long fill
    log_q.delete();
    applyStimulus(REG_ADR, 16'h1000);
    applyStimulus(REG_FILL_LEN, 16'd100);
    applyStimulus(REG_FILL_GO, 16'h0066);
    waitCycles(10);
    applyStimulus(REG_ADR, 16'h0050);
    applyStimulus(REG_DATA, 16'h0058);
    waitCycles(110);
    nfill = 0; found_x = 0;
    foreach (log_q[i]) begin
      if (log_q[i].data == 8'h66) nfill++;
      if (log_q[i].data == 8'h58 && log_q[i].adr == 14'h0050) found_x = 1;
    end
    checkOutput("mix_fill_count", 32'(nfill), 32'd100);
    checkOutput("mix_host_seen", 32'(found_x), 32'd1);
    if (log_q.size() == 101) checkOutput("mix_last_adr", 32'(log_q[100].adr), 32'h1063);

    // Zero-length fill, then a go strobe during an active fill
    log_q.delete();
    applyStimulus(REG_FILL_LEN, 16'd0);
    applyStimulus(REG_FILL_GO, 16'h0031);
    waitCycles(4);
    checkOutput("zero_count", 32'(log_q.size()), 32'd0);
    checkOutput("zero_status", 32'(status), 32'h0004);
    applyStimulus(REG_FILL_LEN, 16'd20);
    applyStimulus(REG_FILL_GO, 16'h002E);
    applyStimulus(REG_FILL_GO, 16'h002F);
    checkOutput("ovf_set", 32'(status[ST_OVERFLOW]), 32'd1);
    applyStimulus(REG_CLR_ERR, 16'd0);
    checkOutput("ovf_clr", 32'(status[ST_OVERFLOW]), 32'd0);
    waitCycles(25);
    checkOutput("ovf_fill_count", 32'(log_q.size()), 32'd20);

    // Reset in the middle of a fill with host entries pending
    applyStimulus(REG_FILL_LEN, 16'd50);
    applyStimulus(REG_FILL_GO, 16'h002A);
    waitCycles(3);
    applyStimulus(REG_DATA, 16'h0011);
    bus.do_write = 1'b1; bus.w_adr = REG_DATA; bus.w_data = 16'h0012;
    #2 nrst = 1'b0;
    bus.do_write = 1'b0;
    #1 checkOutput("rst_mid_we", 32'(chbuf_we), 32'd0);
    checkOutput("rst_mid_adr", 32'(chbuf_adr), 32'd0);
    waitCycles(2);
    nrst = 1'b1;
    log_q.delete();
    @(negedge clk);
    checkOutput("rst_after_status", 32'(status), 32'h0004);
    waitCycles(10);
    checkOutput("rst_after_count", 32'(log_q.size()), 32'd0);

    // Random register traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        logic [7:0]  a;
        logic [15:0] d;
        a = radr_tab[$urandom_range(0, 6)];
        if ($urandom_range(0, 19) == 0) a = 8'($urandom_range(7, 255));
        d = 16'($urandom);
        if (a == REG_FILL_LEN) d = 16'($urandom_range(0, 12));
        if (a == REG_ADR && $urandom_range(0, 1) == 1) d = 16'h3FF8 + 16'($urandom_range(0, 7));
        applyStimulus(a, d);
      end else begin
        @(negedge clk);
      end
    end
    waitCycles(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/charbuf_write_ctrl.md
Name: charbuf_write_ctrl

Overview:
Sequences the single write port of the character buffer (char_buf) on the clk domain. Decodes host register writes from clocked_bus_slave (do_write/w_adr/w_data) into character-cell writes buffered in a small FIFO. Runs a hardware fill engine for clear-screen and region fill, sharing the port with host writes (host has priority). Replaces the ad-hoc chadr/chdata/chbuf_w logic in top and exposes a status word for the read mux.

Parameters:
ADRW, 14, char_buf address width (cells); fill address wraps mod 2^ADRW
DATW, 8, character code width
FIFO_AW, 2, log2 host FIFO depth (default depth 4)

Ports:
clk  in  1  system clock (PLL 108 MHz)
nrst  in  1  reset, asynchronous, active-low
do_write  in  1  one-cycle write strobe from bus slave
w_adr  in  8  register address
w_data  in  16  register write data
status  out  16  status word for register read mux
chbuf_we  out  1  char_buf write enable, one cycle per cell
chbuf_adr  out  ADRW  char_buf write address
chbuf_data  out  DATW  char_buf write data

Behaviour:
- Reset (nrst low, async): host pointer hp=0; fifo empty; fill state IDLE; fill_len=0; overflow=0; chbuf_we=0; chbuf_adr=0; chbuf_data=0.
- Register map (acts only on do_write=1 cycles):
  - 0x00: hp <= w_data[ADRW-1:0].
  - 0x02: push {hp, w_data[DATW-1:0]}; hp unchanged.
  - 0x03: push {hp, w_data[DATW-1:0]}; hp <= hp+1 (wraps mod 2^ADRW). hp increments even if push dropped.
  - 0x04: fill_len <= w_data (cells, 0..65535, saturated to 2^ADRW).
  - 0x05: start fill: fill_adr <= hp, fill_char <= w_data[DATW-1:0], remaining <= fill_len.
  - 0x06: clear overflow.
  - other addresses: ignored.
- FIFO: depth 2^FIFO_AW, entries {ADRW addr, DATW data}. Push when full (registered full flag, irrespective of same-cycle pop) -> entry dropped, overflow <= 1 (sticky).
- Output stage (registered): each cycle, priority 1 = FIFO non-empty: pop, drive entry. Priority 2 = fill state FILL: drive {fill_adr, fill_char}, fill_adr+1 (wrap), remaining-1. Else chbuf_we=0; chbuf_adr/chbuf_data hold last value.
- Latency: do_write in cycle N (0x02/0x03, FIFO empty) -> entry stored at end of N -> chbuf_we=1 during cycle N+2. Back-to-back host writes sustain 1 cell/cycle.
- Fill FSM: IDLE -> FILL on 0x05 if remaining would be nonzero; 0x05 with fill_len=0 -> stays IDLE, no writes. FILL -> IDLE in the cycle the last cell is issued (remaining 1->0). Fill stalls (no advance) on cycles where FIFO wins. 0x05 while FILL -> ignored, overflow <= 1. 0x00/0x03 during FILL only change hp. 0x04 during FILL affects the next fill only.
- Simultaneous host push and fill issue: both proceed (push enters FIFO, fill issues this cycle if FIFO was empty).
- status: [0] fill busy (FILL), [1] fifo full, [2] fifo empty, [3] overflow, [7:4] 0, [15:8] fifo level (zero-extended). Combinational from registers.
- nrst asserted mid-fill/mid-FIFO: all discarded, immediately idle; no further chbuf_we.

Decomposition:
- Shared package: register address constants (REG_ADR=0x00, REG_DATA=0x02, REG_DATA_INC=0x03, REG_FILL_LEN=0x04, REG_FILL_GO=0x05, REG_CLR_ERR=0x06) and status bit indices, also used by top's read mux and firmware header.
- One sub-module: sync_fifo (parameterised width/depth, registered full/empty, level output, nrst async clear).

Test Plan:
- Write 0x00=0x0123, 0x03='A', 0x03='B' -> chbuf_we pulses with (0x0123,0x41), (0x0124,0x42); hp ends 0x0125; first we exactly 2 cycles after first data strobe.
- 0x00=0x3FFE, 0x04=4, 0x05=0x20 -> four writes of 0x20 at 0x3FFE,0x3FFF,0x0000,0x0001; status[0] 1 during, 0 after last.
- During fill of 100 cells, host 0x02='X' at 0x0050 -> X written within 2 cycles, fill pauses 1 cycle, total fill writes still 100, no overlap of we.
- Six back-to-back 0x02 writes during a FIFO stalled by none (depth 4, drained 1/cycle) -> all six written; then force full by holding fifo: 5th push while full -> dropped, status[3]=1, 0x06 clears it.
- 0x04=0 then 0x05 -> no chbuf_we, status[0] stays 0; 0x05 during active fill -> ignored, overflow=1.
- Assert nrst mid-fill with 2 FIFO entries -> chbuf_we=0 immediately, status=0x0004 after release.
